seg7_scan_decoder: RTL and testbench

Readback monitor for the multiplexed 7-segment display path. It snoops the scanned, active-low anode and segment lines driven toward the board, and waits for each anode/segment combination to hold stable. It then decodes each pattern back to a 4-bit hex digit and assembles a full multi-digit value with per-digit valid flags and a once-per-frame strobe. It sits beside the display driver on the peripheral bus side, so the core and the testbench can read back what is actually being shown.

---
 rtl/seg7_scan_decoder.sv | 136 +++++++++++++
 tb/tb_seg7_scan_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - readback monitor for the scanned 7-segment display lines
// Waits for each anode/segment pattern to settle, decodes it to hex and tracks full frames.
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            seg,
  input  logic                  clr_error,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  error
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = DIGITS + 7;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NW = $clog2(DIGITS + 1);

  logic [SW-1:0]       smp, smp_d;
  logic [CW-1:0]       cnt;
  logic [DIGITS-1:0]   seen;
  logic                match, capture;
  logic [DIGITS-1:0]   cap_an;
  logic [6:0]          cap_seg;

  logic [3:0]          dec_digit;
  logic                dec_legal;
  logic [NW-1:0]       n_low;
  logic [IW-1:0]       idx;

  logic [4*DIGITS-1:0] value_n;
  logic [DIGITS-1:0]   dv_n, seen_n, seen_acc;
  logic                fv_n, err_evt;

  assign match   = (smp == smp_d);
  // Fires only on the transition into STABLE_CYCLES-1; saturation keeps it one-shot.
  assign capture = match && (cnt == CW'(STABLE_CYCLES - 1));
  assign cap_an  = smp[SW-1:7];
  assign cap_seg = smp[6:0];

  always_comb begin
    dec_digit = 4'h0;
    dec_legal = 1'b1;
    case (cap_seg)
      7'b1000000: dec_digit = 4'h0;
      7'b1111001: dec_digit = 4'h1;
      7'b0100100: dec_digit = 4'h2;
      7'b0110000: dec_digit = 4'h3;
      7'b0011001: dec_digit = 4'h4;
      7'b0010010: dec_digit = 4'h5;
      7'b0000010: dec_digit = 4'h6;
      7'b1111000: dec_digit = 4'h7;
      7'b0000000: dec_digit = 4'h8;
      7'b0011000: dec_digit = 4'h9;
      7'b0001000: dec_digit = 4'hA;
      7'b0000011: dec_digit = 4'hB;
      7'b1000110: dec_digit = 4'hC;
      7'b0100001: dec_digit = 4'hD;
      7'b0000110: dec_digit = 4'hE;
      7'b0001110: dec_digit = 4'hF;
      default:    dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    n_low = '0;
    idx   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!cap_an[i]) begin
        n_low = n_low + NW'(1);
        idx   = IW'(i);
      end
    end
  end

  always_comb begin
    value_n  = value;
    dv_n     = digit_valid;
    seen_n   = seen;
    seen_acc = seen;
    fv_n     = 1'b0;
    err_evt  = 1'b0;
    if (capture) begin
      if (n_low > NW'(1)) begin
        err_evt = 1'b1;
      end else if (n_low == NW'(1)) begin
        seen_acc = seen | (DIGITS'(1) << idx);
        if (dec_legal) begin
          value_n[{idx, 2'b00} +: 4] = dec_digit;
          dv_n[idx]                  = 1'b1;
        end else begin
          dv_n[idx] = 1'b0;
          // An all-off digit is a legitimate blank, not a fault.
          if (cap_seg != 7'h7F) err_evt = 1'b1;
        end
        if (&seen_acc) begin
          fv_n   = 1'b1;
          seen_n = '0;
        end else begin
          seen_n = seen_acc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp         <= '1;
      smp_d       <= '1;
      cnt         <= '0;
      seen        <= '0;
      value       <= '0;
      digit_valid <= '0;
      frame_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      smp   <= {an, seg};
      smp_d <= smp;
      if (match) begin
        if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      seen        <= seen_n;
      value       <= value_n;
      digit_valid <= dv_n;
      frame_valid <= fv_n;
      error       <= err_evt | (error & ~clr_error);
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed self-checking bench for seg7_scan_decoder
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        clr_error;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        error;

  int vectors    = 0;
  int miscompares = 0;
  int fv_pulses  = 0;
  logic [15:0] fv_val;

  seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .clr_error(clr_error),
    .value(value), .digit_valid(digit_valid), .frame_valid(frame_valid), .error(error)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (frame_valid) begin
        fv_pulses++;
        fv_val = value;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; clr_error = 1'b0; an = 4'b0000; seg = 7'b0101010;
    cyc(3);
    vectors++; if (value !== 16'h0000) begin miscompares++; $display("FAIL reset_value: got %h expected 0000", value); end
    vectors++; if (digit_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_dv: got %b expected 0000", digit_valid); end
    vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b expected 0", error); end
    an = 4'b1111; seg = 7'b1111111;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic test_full_frame;
    fv_pulses = 0;
    an = 4'b1110; seg = 7'b0001110;
    cyc(17);
    vectors++; if (value !== 16'h0000) begin miscompares++; $display("FAIL latency_early: got %h expected 0000", value); end
    cyc(1);
    vectors++; if (value !== 16'h000F) begin miscompares++; $display("FAIL latency_value: got %h expected 000f", value); end
    vectors++; if (digit_valid !== 4'b0001) begin miscompares++; $display("FAIL latency_dv: got %b expected 0001", digit_valid); end
    hold(4'b1110, 7'b0001110, 2);
    hold(4'b1101, 7'b0110000, 20);
    hold(4'b1011, 7'b0001000, 20);
    vectors++; if (fv_pulses !== 0) begin miscompares++; $display("FAIL frame_early: got %0d pulses expected 0", fv_pulses); end
    hold(4'b0111, 7'b1111001, 100);
    vectors++; if (fv_pulses !== 1) begin miscompares++; $display("FAIL frame_pulses: got %0d pulses expected 1", fv_pulses); end
    vectors++; if (fv_val !== 16'h1A3F) begin miscompares++; $display("FAIL frame_value_at_pulse: got %h expected 1a3f", fv_val); end
    vectors++; if (value !== 16'h1A3F) begin miscompares++; $display("FAIL frame_value: got %h expected 1a3f", value); end
    vectors++; if (digit_valid !== 4'b1111) begin miscompares++; $display("FAIL frame_dv: got %b expected 1111", digit_valid); end
  endtask

  task automatic test_glitch;
    hold(4'b1110, 7'b1111001, 15);
    hold(4'b1111, 7'b1111111, 20);
    vectors++; if (value !== 16'h1A3F) begin miscompares++; $display("FAIL glitch_value: got %h expected 1a3f", value); end
    vectors++; if (digit_valid !== 4'b1111) begin miscompares++; $display("FAIL glitch_dv: got %b expected 1111", digit_valid); end
  endtask

  task automatic test_illegal;
    hold(4'b1011, 7'b1010101, 20);
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL illegal_error: got %b expected 1", error); end
    vectors++; if (digit_valid !== 4'b1011) begin miscompares++; $display("FAIL illegal_dv: got %b expected 1011", digit_valid); end
    vectors++; if (value !== 16'h1A3F) begin miscompares++; $display("FAIL illegal_value: got %h expected 1a3f", value); end
    hold(4'b1111, 7'b1111111, 20);
    clr_error = 1'b1;
    cyc(1);
    clr_error = 1'b0;
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL clr_error: got %b expected 0", error); end
    an = 4'b1011; seg = 7'b1010101;
    cyc(17);
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL illegal_early: got %b expected 0", error); end
    clr_error = 1'b1;
    cyc(1);
    clr_error = 1'b0;
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL clr_vs_event: got %b expected 1", error); end
    hold(4'b1011, 7'b1010101, 2);
    hold(4'b1111, 7'b1111111, 20);
    clr_error = 1'b1;
    cyc(1);
    clr_error = 1'b0;
  endtask

  task automatic test_blank_digit;
    hold(4'b1110, 7'b1111111, 20);
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL blank_error: got %b expected 0", error); end
    vectors++; if (digit_valid !== 4'b1010) begin miscompares++; $display("FAIL blank_dv: got %b expected 1010", digit_valid); end
    vectors++; if (value !== 16'h1A3F) begin miscompares++; $display("FAIL blank_value: got %h expected 1a3f", value); end
  endtask

  task automatic test_multi_anode;
    fv_pulses = 0;
    hold(4'b1100, 7'b0000000, 20);
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL multi_error: got %b expected 1", error); end
    vectors++; if (value !== 16'h1A3F) begin miscompares++; $display("FAIL multi_value: got %h expected 1a3f", value); end
    vectors++; if (digit_valid !== 4'b1010) begin miscompares++; $display("FAIL multi_dv: got %b expected 1010", digit_valid); end
    hold(4'b1101, 7'b0000000, 20);
    vectors++; if (fv_pulses !== 0) begin miscompares++; $display("FAIL multi_frame_early: got %0d pulses expected 0", fv_pulses); end
    hold(4'b0111, 7'b1111000, 20);
    vectors++; if (fv_pulses !== 1) begin miscompares++; $display("FAIL multi_frame: got %0d pulses expected 1", fv_pulses); end
    vectors++; if (value !== 16'h7A8F) begin miscompares++; $display("FAIL multi_final_value: got %h expected 7a8f", value); end
    vectors++; if (digit_valid !== 4'b1010) begin miscompares++; $display("FAIL multi_final_dv: got %b expected 1010", digit_valid); end
    hold(4'b1111, 7'b1111111, 20);
    clr_error = 1'b1;
    cyc(1);
    clr_error = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    fv_pulses = 0;
    hold(4'b1110, 7'b1000000, 20);
    hold(4'b1101, 7'b0000110, 20);
    an = 4'b1111; seg = 7'b1111111;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    vectors++; if (value !== 16'h0000) begin miscompares++; $display("FAIL midrst_value: got %h expected 0000", value); end
    hold(4'b1011, 7'b1000110, 20);
    hold(4'b0111, 7'b0100001, 20);
    vectors++; if (fv_pulses !== 0) begin miscompares++; $display("FAIL midrst_no_frame: got %0d pulses expected 0", fv_pulses); end
    vectors++; if (value !== 16'hDC00) begin miscompares++; $display("FAIL midrst_partial_value: got %h expected dc00", value); end
    hold(4'b1110, 7'b0000011, 20);
    vectors++; if (fv_pulses !== 0) begin miscompares++; $display("FAIL midrst_frame_early: got %0d pulses expected 0", fv_pulses); end
    hold(4'b1101, 7'b0011000, 20);
    vectors++; if (fv_pulses !== 1) begin miscompares++; $display("FAIL midrst_frame: got %0d pulses expected 1", fv_pulses); end
    vectors++; if (value !== 16'hDC9B) begin miscompares++; $display("FAIL midrst_final_value: got %h expected dc9b", value); end
    vectors++; if (digit_valid !== 4'b1111) begin miscompares++; $display("FAIL midrst_final_dv: got %b expected 1111", digit_valid); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL midrst_error: got %b expected 0", error); end
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_glitch;
    test_illegal;
    test_blank_digit;
    test_multi_anode;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
